// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: opcodes, FSM states and default widths.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CTRL_WIDTH = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU. Shift opcodes pass operand a through unchanged;
// the sequencer around it performs the actual bit-serial shift.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ALU_CTRL_WIDTH = DEFAULT_CTRL_WIDTH
) (
  input  logic [ALU_CTRL_WIDTH-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      carry,
  output logic                      illegal
);

  logic [DATA_WIDTH:0] sum;

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    illegal = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    case (ctrl)
      ALU_CTRL_WIDTH'(ALU_ADD): begin
        result = sum[DATA_WIDTH-1:0];
        carry  = sum[DATA_WIDTH];
      end
      ALU_CTRL_WIDTH'(ALU_SUB): result = a - b;
      ALU_CTRL_WIDTH'(ALU_AND): result = a & b;
      ALU_CTRL_WIDTH'(ALU_OR):  result = a | b;
      ALU_CTRL_WIDTH'(ALU_SLL),
      ALU_CTRL_WIDTH'(ALU_SRL): result = a;
      default:                  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Request/response wrapper around the ALU: single-cycle ops finish in one cycle,
// SLL/SRL shift one bit per cycle in a local shift register.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ALU_CTRL_WIDTH = DEFAULT_CTRL_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ALU_CTRL_WIDTH-1:0] req_ctrl,
  input  logic [DATA_WIDTH-1:0]     req_a,
  input  logic [DATA_WIDTH-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_overflow,
  output logic                      rsp_exception
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] result_reg, result_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [SHAMT_W-1:0]    count_reg, count_next;
  logic                  dir_right_reg, dir_right_next;
  logic                  overflow_reg, overflow_next;
  logic                  exception_reg, exception_next;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_illegal;
  logic [SHAMT_W-1:0]    shamt;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] shifted;

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ALU_CTRL_WIDTH(ALU_CTRL_WIDTH)
  ) u_alu (
    .ctrl   (req_ctrl),
    .a      (req_a),
    .b      (req_b),
    .result (alu_result),
    .carry  (alu_carry),
    .illegal(alu_illegal)
  );

  assign shamt    = req_b[SHAMT_W-1:0];
  assign is_shift = (req_ctrl == ALU_CTRL_WIDTH'(ALU_SLL)) ||
                    (req_ctrl == ALU_CTRL_WIDTH'(ALU_SRL));
  assign shifted  = dir_right_reg ? (shift_reg >> 1) : (shift_reg << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      shift_reg     <= '0;
      count_reg     <= '0;
      dir_right_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      exception_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      result_reg    <= result_next;
      shift_reg     <= shift_next;
      count_reg     <= count_next;
      dir_right_reg <= dir_right_next;
      overflow_reg  <= overflow_next;
      exception_reg <= exception_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    result_next    = result_reg;
    shift_next     = shift_reg;
    count_next     = count_reg;
    dir_right_next = dir_right_reg;
    overflow_next  = overflow_reg;
    exception_next = exception_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_shift && (shamt != '0)) begin
            shift_next     = req_a;
            count_next     = shamt;
            dir_right_next = (req_ctrl == ALU_CTRL_WIDTH'(ALU_SRL));
            state_next     = ST_EXEC;
          end else begin
            // Zero shift amount lands here too: the ALU passes a through.
            result_next    = alu_result;
            overflow_next  = alu_carry;
            exception_next = alu_illegal;
            state_next     = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        shift_next = shifted;
        count_next = count_reg - 1'b1;
        if (count_reg == SHAMT_W'(1)) begin
          result_next    = shifted;
          overflow_next  = 1'b0;
          exception_next = 1'b0;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          result_next    = '0;
          overflow_next  = 1'b0;
          exception_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready     = (state_reg == ST_IDLE);
  assign rsp_valid     = (state_reg == ST_DONE);
  assign rsp_result    = rsp_valid ? result_reg : '0;
  assign rsp_zero      = rsp_valid && (result_reg == '0);
  assign rsp_overflow  = rsp_valid && overflow_reg;
  assign rsp_exception = rsp_valid && exception_reg;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: hand-computed vectors, checks sampled on the falling edge.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ctrl;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_exception;

  int errors = 0;
  int checks = 0;

  alu_seq_unit #(.DATA_WIDTH(32), .ALU_CTRL_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ctrl     (req_ctrl),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_exception(rsp_exception)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge while idle. Returns at the first falling edge with
  // rsp_valid high (or after a bounded wait) and the cycle count since accept.
  // req_valid stays high with scrambled operands while busy so that ignored
  // inputs are exercised; it drops before the response handshake edge.
  task automatic issue(input string tag, input logic [3:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    logic busy_ok;
    req_ctrl  = ctrl;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    check({tag, "_ready_at_accept"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_ctrl = 4'b0010;
    req_a    = $urandom;
    req_b    = $urandom;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!rsp_valid && lat < 64) begin
      if (req_ready !== 1'b0 || rsp_result !== 32'd0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
      req_a = $urandom;
    end
    req_valid = 1'b0;
    check({tag, "_busy_quiet"}, {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic check_rsp(input string tag, input int lat, input int exp_lat,
                           input logic [31:0] res, input logic z, input logic ov,
                           input logic ex);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_result"}, rsp_result, res);
    check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
    check({tag, "_overflow"}, {31'd0, rsp_overflow}, {31'd0, ov});
    check({tag, "_exception"}, {31'd0, rsp_exception}, {31'd0, ex});
    check({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
    $display("txn %s: result=0x%08h latency=%0d", tag, rsp_result, lat);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle_result"}, rsp_result, 32'd0);
    check({tag, "_idle_flags"}, {29'd0, rsp_zero, rsp_overflow, rsp_exception}, 32'd0);
  endtask

  initial begin
    int  lat;
    logic stable_ok;
    logic never_valid;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_ctrl  = 4'b0000;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // ADD 300+200, first accept right after reset release
    issue("add_300_200", 4'b0010, 32'd300, 32'd200, lat);
    check_rsp("add_300_200", lat, 1, 32'd500, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("add_300_200");

    issue("add_carry", 4'b0010, 32'hAAAAAAAA, 32'hBBBBBBBB, lat);
    check_rsp("add_carry", lat, 1, 32'h66666665, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    issue("sub", 4'b0110, 32'd1324, 32'd203, lat);
    check_rsp("sub", lat, 1, 32'd1121, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    issue("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
    check_rsp("and", lat, 1, 32'h00F0_1200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    issue("sll", 4'b1000, 32'd12, 32'd4, lat);
    check_rsp("sll", lat, 5, 32'd192, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    issue("srl", 4'b1001, 32'd12301233, 32'd12, lat);
    check_rsp("srl", lat, 13, 32'd3003, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // b=36: only the low five bits count, so shift by 4
    issue("sll_upper_b", 4'b1000, 32'h8000_0001, 32'd36, lat);
    check_rsp("sll_upper_b", lat, 5, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // b=32 gives shamt 0: no EXEC, result is a
    issue("sll_zero", 4'b1000, 32'hDEAD_BEEF, 32'd32, lat);
    check_rsp("sll_zero", lat, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    issue("illegal", 4'b1111, 32'd5, 32'd7, lat);
    check_rsp("illegal", lat, 1, 32'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);

    // OR with back-pressure: held 3 cycles, handshake on the 4th
    rsp_ready = 1'b0;
    issue("or_hold", 4'b0001, 32'h0FFF3213, 32'h0ABCD231, lat);
    check_rsp("or_hold", lat, 1, 32'h0FFFF233, 1'b0, 1'b0, 1'b0);
    stable_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h0FFFF233 || req_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    check("or_hold_stable", {31'd0, stable_ok}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    check_idle("or_hold");

    // SRL by 20 aborted by reset 5 cycles after accept
    req_ctrl  = 4'b1001;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'd20;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort");
    never_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) never_valid = 1'b0;
    end
    check("abort_no_rsp", {31'd0, never_valid}, 32'd1);

    issue("add_after_abort", 4'b0010, 32'd1, 32'd1, lat);
    check_rsp("add_after_abort", lat, 1, 32'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("add_after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
